// File: rtl/n64_blur_estimator_gen2.sv
// Blur estimator for the demuxed N64 video bus: counts sharp gradient reversals around the
// potentially blurry pixel, filters them per frame and drives the de-blur / RGB blanking controls.
module n64_blur_estimator_gen2 #(
    parameter int COLOR_WIDTH = 7,
    parameter int CMP_MSB     = 6,
    parameter int CMP_LSB     = 5,
    parameter int TREND_WIDTH = 9,
    parameter int TREND_HI    = 264,
    parameter int TREND_LO    = 248,
    parameter int HIT_TH      = 2,
    parameter int MIN_CHANGES = 3,
    parameter int HOLDOFF_LEN = 3,
    parameter int LINE_SKIP   = 3
) (
    input  logic                   nCLK,
    input  logic                   RST,
    input  logic                   nDSYNC,
    input  logic [COLOR_WIDTH-1:0] D_i,
    input  logic [1:0]             data_cnt,
    input  logic                   blurry_pixel_pos,
    input  logic                   n64_480i,
    input  logic                   vmode,
    input  logic                   nForceDeBlur,
    input  logic                   nDeBlurMan,
    output logic                   ndo_deblur,
    output logic                   nblank_rgb,
    output logic                   nblur_n64,
    output logic [TREND_WIDTH-1:0] trend,
    output logic                   est_valid
);

    localparam int SW = CMP_MSB - CMP_LSB + 1;
    localparam logic [TREND_WIDTH-1:0] TREND_INIT = TREND_WIDTH'(1 << (TREND_WIDTH - 1));
    localparam logic [TREND_WIDTH-1:0] TREND_MAX  = '1;
    localparam logic [TREND_WIDTH-1:0] TREND_HI_V = TREND_WIDTH'(TREND_HI);
    localparam logic [TREND_WIDTH-1:0] TREND_LO_V = TREND_WIDTH'(TREND_LO);

    logic [3:0]             sync_cur_q, sync_cur_d;
    logic [3:0]             sync_pre_q, sync_pre_d;
    logic [2:0][SW-1:0]     prev_q, prev_d;
    logic [2:0][1:0]        grad_q, grad_d;
    logic [LINE_SKIP-1:0]   run_q, run_d;
    logic [1:0]             rev_cnt_q, rev_cnt_d;
    logic [2:0]             holdoff_q, holdoff_d;
    logic [2:0]             hit_cnt_q, hit_cnt_d;
    logic [TREND_WIDTH-1:0] trend_q, trend_d;
    logic                   nblur_q, nblur_d;
    logic                   ndo_q, ndo_d;
    logic                   nblank_q, nblank_d;
    logic                   valid_q, valid_d;

    logic [SW-1:0] cur_slice;
    logic [SW-1:0] prev_sel;
    logic [1:0]    grad_new;
    logic [2:0]    chan_sel;
    logic          act_window;
    logic          frame_start;
    logic          line_start;
    logic          run_active;
    logic          unused_bits;

    assign unused_bits = ^D_i;

    assign cur_slice   = D_i[CMP_MSB:CMP_LSB];
    assign chan_sel    = {data_cnt == 2'b11, data_cnt == 2'b10, data_cnt == 2'b01};
    assign act_window  = sync_cur_q[3] & sync_cur_q[1] & sync_pre_q[3] & sync_pre_q[1];
    assign frame_start = ~nDSYNC & sync_cur_q[3] & ~D_i[3];
    assign line_start  = ~nDSYNC & sync_cur_q[0] & ~D_i[0];
    assign run_active  = run_q[LINE_SKIP-1];

    always_comb begin
        prev_sel = '0;
        for (int c = 0; c < 3; c++) begin
            if (chan_sel[c]) prev_sel = prev_q[c];
        end
    end

    // {rising, falling} of the compared slice versus the same channel one pixel earlier
    assign grad_new = {prev_sel < cur_slice, prev_sel > cur_slice};

    always_comb begin
        sync_cur_d = sync_cur_q;
        sync_pre_d = sync_pre_q;
        prev_d     = prev_q;
        grad_d     = grad_q;
        run_d      = run_q;
        rev_cnt_d  = rev_cnt_q;
        holdoff_d  = holdoff_q;
        hit_cnt_d  = hit_cnt_q;
        trend_d    = trend_q;
        nblur_d    = nblur_q;
        ndo_d      = ndo_q;
        nblank_d   = nblank_q;
        valid_d    = valid_q;

        if (nDSYNC) begin
            for (int c = 0; c < 3; c++) begin
                if (chan_sel[c]) begin
                    prev_d[c] = cur_slice;
                    if (act_window) begin
                        if (blurry_pixel_pos) begin
                            grad_d[c] = grad_new;
                        end else if (run_active && ((grad_q[c] ^ grad_new) == 2'b11) &&
                                     (rev_cnt_q != 2'd3)) begin
                            rev_cnt_d = rev_cnt_q + 2'd1;
                        end
                    end
                end
            end
            if (!act_window) begin
                grad_d = '0;
                run_d  = '0;
            end
        end else begin
            sync_pre_d = sync_cur_q;
            sync_cur_d = D_i[3:0];

            if (!blurry_pixel_pos) begin
                run_d = (run_q << 1) | LINE_SKIP'(1);
                if (holdoff_q != 3'd0) begin
                    holdoff_d = (holdoff_q == 3'(HOLDOFF_LEN)) ? 3'd0 : holdoff_q + 3'd1;
                end
                if (rev_cnt_q >= 2'(MIN_CHANGES)) begin
                    if ((holdoff_q == 3'd0) && (hit_cnt_q < 3'(HIT_TH))) begin
                        hit_cnt_d = hit_cnt_q + 3'd1;
                    end
                    holdoff_d = 3'd1;
                end
                rev_cnt_d = 2'd0;
            end

            if (line_start) begin
                run_d     = '0;
                holdoff_d = 3'd0;
            end

            if (frame_start) begin
                if (hit_cnt_q >= 3'(HIT_TH)) begin
                    if (trend_q != TREND_MAX) trend_d = trend_q + 1'b1;
                end else if (trend_q != '0) begin
                    trend_d = trend_q - 1'b1;
                end
                if (trend_q >= TREND_HI_V) begin
                    nblur_d = 1'b1;
                end else if (trend_q < TREND_LO_V) begin
                    nblur_d = 1'b0;
                end
                hit_cnt_d = 3'd0;
                valid_d   = 1'b1;
                // registered estimate, so the de-blur decision trails it by one frame
                ndo_d     = n64_480i | (nForceDeBlur ? nblur_q : nDeBlurMan);
            end

            if (ndo_q) begin
                nblank_d = 1'b1;
            end else if (line_start) begin
                nblank_d = vmode;
            end else begin
                nblank_d = ~nblank_q;
            end
        end

        if (n64_480i) begin
            trend_d = TREND_INIT;
            nblur_d = 1'b1;
        end
    end

    always_ff @(negedge nCLK) begin
        if (RST) begin
            sync_cur_q <= '0;
            sync_pre_q <= '0;
            prev_q     <= '0;
            grad_q     <= '0;
            run_q      <= '0;
            rev_cnt_q  <= '0;
            holdoff_q  <= '0;
            hit_cnt_q  <= '0;
            trend_q    <= TREND_INIT;
            nblur_q    <= 1'b1;
            ndo_q      <= 1'b1;
            nblank_q   <= 1'b1;
            valid_q    <= 1'b0;
        end else begin
            sync_cur_q <= sync_cur_d;
            sync_pre_q <= sync_pre_d;
            prev_q     <= prev_d;
            grad_q     <= grad_d;
            run_q      <= run_d;
            rev_cnt_q  <= rev_cnt_d;
            holdoff_q  <= holdoff_d;
            hit_cnt_q  <= hit_cnt_d;
            trend_q    <= trend_d;
            nblur_q    <= nblur_d;
            ndo_q      <= ndo_d;
            nblank_q   <= nblank_d;
            valid_q    <= valid_d;
        end
    end

    assign ndo_deblur = ndo_q;
    assign nblank_rgb = nblank_q;
    assign nblur_n64  = nblur_q;
    assign trend      = trend_q;
    assign est_valid  = valid_q;

endmodule
